// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed scan controller for an 8-digit common-anode seg7 display
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous active-high reset
//   i_wr_en          load i_wr_data as the next display value (committed at frame boundary)
//   i_wr_data        32-bit display value, nibble i -> digit i
//   i_cfg_wr         load i_cfg_digit_en / i_cfg_dp
//   i_cfg_digit_en   per-digit enable (0 keeps that anode off)
//   i_cfg_dp         per-digit decimal point (1 = lit)
//   o_an             anode selects, active-low
//   o_digit_hex      nibble for the shared external seg7 decoder
//   o_dp_n           decimal point, active-low
//   o_frame_done     one-cycle pulse after the last digit's SHOW phase
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [31:0]           i_wr_data,
    input  logic                  i_cfg_wr,
    input  logic [NUM_DIGITS-1:0] i_cfg_digit_en,
    input  logic [NUM_DIGITS-1:0] i_cfg_dp,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic [3:0]            o_digit_hex,
    output logic                  o_dp_n,
    output logic                  o_frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [31:0]           r_disp_val;
    logic [31:0]           r_pend_val;
    logic                  r_pend_valid;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic [NUM_DIGITS-1:0] r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic [3:0]            r_digit_hex;
    logic                  r_dp_n;
    logic                  r_frame_done;

    logic                  w_blank_end;
    logic                  w_show_end;
    logic                  w_wrap;
    logic [31:0]           w_disp_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic [NUM_DIGITS-1:0] w_an_sel;
    logic                  w_dp_sel;

    always_comb begin
        w_blank_end = (r_state == ST_BLANK) && (r_cnt == CNT_W'(BLANK_CYC - 1));
        w_show_end  = (r_state == ST_SHOW)  && (r_cnt == CNT_W'(SCAN_DIV - 1));
        w_wrap      = w_show_end && (r_idx == IDX_W'(NUM_DIGITS - 1));

        // Frame commit: a write landing on the commit edge bypasses the pending register.
        w_disp_next = r_disp_val;
        if (w_wrap) begin
            if (i_wr_en) begin
                w_disp_next = i_wr_data;
            end else if (r_pend_valid) begin
                w_disp_next = r_pend_val;
            end
        end

        w_idx_next = r_idx;
        if (w_show_end) begin
            w_idx_next = w_wrap ? IDX_W'(0) : r_idx + 1'b1;
        end

        w_an_sel = ~({{(NUM_DIGITS-1){1'b0}}, r_digit_en[r_idx]} << r_idx);
        w_dp_sel = ~(r_dp[r_idx] & r_digit_en[r_idx]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_disp_val   <= '0;
            r_pend_val   <= '0;
            r_pend_valid <= 1'b0;
            r_digit_en   <= '1;
            r_dp         <= '0;
            r_an         <= '1;
            r_digit_hex  <= '0;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            if (i_cfg_wr) begin
                r_digit_en <= i_cfg_digit_en;
                r_dp       <= i_cfg_dp;
            end

            r_disp_val <= w_disp_next;
            if (w_wrap) begin
                r_pend_valid <= 1'b0;
            end else if (i_wr_en) begin
                r_pend_val   <= i_wr_data;
                r_pend_valid <= 1'b1;
            end

            r_idx        <= w_idx_next;
            r_frame_done <= w_wrap;

            case (r_state)
                ST_BLANK: begin
                    if (w_blank_end) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHOW;
                        r_an    <= w_an_sel;
                        r_dp_n  <= w_dp_sel;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_an        <= '1;
                        r_dp_n      <= 1'b1;
                        r_digit_hex <= r_disp_val[4*r_idx +: 4];
                    end
                end
                default: begin
                    if (w_show_end) begin
                        r_cnt       <= '0;
                        r_state     <= ST_BLANK;
                        r_an        <= '1;
                        r_dp_n      <= 1'b1;
                        // Preload the next digit's nibble so the decoder settles during BLANK.
                        r_digit_hex <= w_disp_next[4*w_idx_next +: 4];
                    end else begin
                        // Re-evaluated every cycle so a mid-SHOW cfg write shows up one cycle later.
                        r_cnt  <= r_cnt + 1'b1;
                        r_an   <= w_an_sel;
                        r_dp_n <= w_dp_sel;
                    end
                end
            endcase
        end
    end

    assign o_an         = r_an;
    assign o_digit_hex  = r_digit_hex;
    assign o_dp_n       = r_dp_n;
    assign o_frame_done = r_frame_done;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexes one shared seg7 hex-to-segment decoder across an 8-digit common-anode display on the SoC board.
- Holds a 32-bit display value, one nibble per digit. Digit 0 is bits [3:0].
- Each digit is selected in turn, with a blanking gap between digits to suppress ghosting.
- The block drives the 4-bit nibble into the external decoder and drives the anode and decimal-point lines directly.
- New values are double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 8: number of digits scanned. Legal range 2..8.
- SCAN_DIV, 50000: clock cycles each digit stays lit (SHOW phase). Must be ≥ 1.
- BLANK_CYC, 16: clock cycles all anodes are off before each digit (BLANK phase). Must be ≥ 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: load wr_data into the pending value register.
- wr_data, input, 32: new display value, nibble i belongs to digit i.
- cfg_wr, input, 1: load the cfg_digit_en and cfg_dp registers.
- cfg_digit_en, input, NUM_DIGITS: per-digit enable. A 0 keeps that digit's anode off during its slot.
- cfg_dp, input, NUM_DIGITS: per-digit decimal point, 1 = lit.
- an, output, NUM_DIGITS: anode selects, active-low.
- digit_hex, output, 4: nibble sent to the shared seg7 decoder.
- dp_n, output, 1: decimal point, active-low.
- frame_done, output, 1: one-cycle pulse when the last digit's SHOW phase ends.

Behaviour:
- Reset (async, immediate):
  - Outputs: an all 1, digit_hex 0, dp_n 1, frame_done 0.
  - State: BLANK, idx 0, cycle counter 0.
  - Registers: disp_val 0, pend_val 0, pend_valid 0, digit_en all 1, dp all 0.
  - Reset asserted mid-scan abandons the frame; after release the scan restarts at digit 0 in BLANK.
- All outputs are registered and change on the same edge as the state/idx update.
- Counter width is clog2(max(SCAN_DIV, BLANK_CYC)) + 1.
- State machine has two states: BLANK and SHOW.
  - BLANK:
    - an all 1, dp_n 1.
    - digit_hex is preloaded with disp_val[4*idx +: 4] so the decoder output has settled before the anode turns on.
    - After BLANK_CYC cycles the counter clears and the state moves to SHOW.
  - SHOW:
    - an[idx] = ~digit_en[idx]; all other anode bits are 1.
    - dp_n = ~(dp[idx] & digit_en[idx]).
    - digit_hex holds its BLANK value.
    - After SCAN_DIV cycles the counter clears and the state returns to BLANK.
    - At that transition, if idx < NUM_DIGITS-1, idx increments.
    - Otherwise idx wraps to 0, frame_done pulses for 1 cycle, and the frame commit occurs.
- Frame length is NUM_DIGITS × (BLANK_CYC + SCAN_DIV) cycles.
- Frame commit:
  - If pend_valid: disp_val ← pend_val and pend_valid is cleared.
  - If wr_en is high on the commit edge itself, wr_data is committed directly. pend_valid stays 0.
- wr_en outside the commit edge: pend_val ← wr_data and pend_valid ← 1. A later write overwrites an earlier uncommitted one (last write wins).
- cfg_wr:
  - Updates digit_en and dp on the next edge.
  - Takes effect immediately, mid-frame allowed. If it hits during SHOW, the current digit's an and dp_n follow the new value one cycle later.
- cfg_digit_en all 0: the scan keeps running and frame_done keeps pulsing, but an stays all 1.
- The block never stalls. No input back-pressure exists; wr_en and cfg_wr are accepted every cycle.

Test Plan (SCAN_DIV=4, BLANK_CYC=2, NUM_DIGITS=8):
- Reset release: check an=FF, dp_n=1 for the first 2 cycles. Then an=FE with digit_hex=0 for 4 cycles, then an=FF for 2 cycles. frame_done first pulses at cycle 48.
- wr_data=0x89ABCDEF written mid-frame: the current frame still shows 0. In the next frame, digit_hex per slot reads F,E,D,C,B,A,9,8 with an=FE,FD,…,7F.
- Two writes in one frame (0x11111111, then 0x22222222): only 2 is displayed next frame. Separately, wr_en=1 on the frame_done edge commits in that same edge, so the first digit of the next frame shows the new value.
- cfg_digit_en=0xF0, cfg_dp=0x01: slots 0–3 keep an=FF; slot 4 drives an=EF. dp_n stays 1 everywhere, because digit 0 is disabled.
- cfg_dp=0x04 with all digits enabled: dp_n=0 only during digit 2's SHOW phase. digit_hex for each digit is stable for all 2 BLANK cycles before its anode goes low.
- Assert rst during digit 5's SHOW phase: an=FF and dp_n=1 immediately (asynchronous, before the next edge). On release the scan restarts at digit 0 with disp_val=0.
